// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
//
// Vehicle-detector front end for a two-road traffic light controller. There is
// one channel per road (A and B). Each channel does the following:
//   - passes the raw loop-detector level through a two-flop synchronizer,
//   - debounces it into a filtered level,
//   - counts arrivals (0->1 transitions of the filtered level) with saturation,
//   - latches a request until the controller serves the road with green,
//   - flags a detector whose filtered level stays high too long (stuck).
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high; clears all state
//   loop_a, loop_b   raw detector levels, asynchronous to clk
//   Ga, Gb           green (served) indication from the controller
//   Sa, Sb           vehicle request to the controller (register-decoded)
//   count_a, count_b saturating arrival counters, CNT_W bits
//   fault_a, fault_b detector stuck-high flags

module traffic_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 1024,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_a,
    input  logic             loop_b,
    input  logic             Ga,
    input  logic             Gb,
    output logic             Sa,
    output logic             Sb,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic             fault_a,
    output logic             fault_b
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SCNT_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]       loop_in;
    logic [1:0]       green_in;
    logic [1:0]       sreq_out;
    logic [1:0]       fault_out;
    logic [CNT_W-1:0] cnt_out [2];

    assign loop_in  = {loop_b, loop_a};
    assign green_in = {Gb, Ga};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic              s1_q, s2_q;
        logic              filt_q, filt_d;
        logic [DCNT_W-1:0] dcnt_q, dcnt_d;
        logic              req_q, req_d;
        logic [SCNT_W-1:0] scnt_q, scnt_d;
        logic              fault_q, fault_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              arrival;

        always_comb begin
            filt_d  = filt_q;
            dcnt_d  = '0;
            cnt_d   = cnt_q;
            req_d   = req_q;
            scnt_d  = scnt_q;
            fault_d = fault_q;

            // Debounce: the filtered level follows only after the synchronized
            // input has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
            if (s2_q != filt_q) begin
                if (dcnt_q == DCNT_LAST) begin
                    filt_d = s2_q;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            arrival = filt_d & ~filt_q;

            if (arrival && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Green clears the latch and wins over a same-cycle arrival.
            if (green_in[ch]) begin
                req_d = 1'b0;
            end else if (arrival) begin
                req_d = 1'b1;
            end

            // Stuck detect counts cycles the filtered level has been high;
            // the cycle it falls clears both counter and flag.
            if (!filt_d) begin
                scnt_d  = '0;
                fault_d = 1'b0;
            end else begin
                if (filt_q && (scnt_q != SCNT_MAX)) begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
                if (scnt_d == SCNT_MAX) begin
                    fault_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                filt_q  <= 1'b0;
                dcnt_q  <= '0;
                req_q   <= 1'b0;
                scnt_q  <= '0;
                fault_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                s1_q    <= loop_in[ch];
                s2_q    <= s1_q;
                filt_q  <= filt_d;
                dcnt_q  <= dcnt_d;
                req_q   <= req_d;
                scnt_q  <= scnt_d;
                fault_q <= fault_d;
                cnt_q   <= cnt_d;
            end
        end

        // A stuck detector alone cannot keep the request asserted.
        assign sreq_out[ch]  = req_q | (filt_q & ~fault_q);
        assign fault_out[ch] = fault_q;
        assign cnt_out[ch]   = cnt_q;
    end

    assign Sa      = sreq_out[0];
    assign Sb      = sreq_out[1];
    assign fault_a = fault_out[0];
    assign fault_b = fault_out[1];
    assign count_a = cnt_out[0];
    assign count_b = cnt_out[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner: directed scenarios followed
// by random detector/green activity, all compared every cycle against a
// behavioural model of the channel rules.

module tb_traffic_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int STK  = 16;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          loop_a, loop_b, Ga, Gb;
    logic          Sa, Sb, fault_a, fault_b;
    logic [CW-1:0] count_a, count_b;

    int checks = 0;
    int passed = 0;

    // Model state, index 0 = road A, 1 = road B.
    int m_s1 [2];
    int m_s2 [2];
    int m_filt [2];
    int m_req [2];
    int m_cnt [2];
    int m_fault [2];
    int m_rise [2];
    int hist [2][DEB];
    int hfill [2];
    int edge_no = 0;

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .STUCK_CYCLES   (STK),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .loop_a (loop_a),
        .loop_b (loop_b),
        .Ga     (Ga),
        .Gb     (Gb),
        .Sa     (Sa),
        .Sb     (Sb),
        .count_a(count_a),
        .count_b(count_b),
        .fault_a(fault_a),
        .fault_b(fault_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        int lp [2];
        int gr [2];
        int flip, nf, arrival;
        lp[0] = int'(loop_a);
        lp[1] = int'(loop_b);
        gr[0] = int'(Ga);
        gr[1] = int'(Gb);
        edge_no++;
        for (int ch = 0; ch < 2; ch++) begin
            if (reset) begin
                m_s1[ch] = 0; m_s2[ch] = 0; m_filt[ch] = 0; m_req[ch] = 0;
                m_cnt[ch] = 0; m_fault[ch] = 0; m_rise[ch] = 0; hfill[ch] = 0;
                continue;
            end
            // Window of the last DEB synchronized samples seen at the edges.
            for (int i = DEB - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
            hist[ch][0] = m_s2[ch];
            if (hfill[ch] < DEB) hfill[ch]++;
            flip = (hfill[ch] == DEB) ? 1 : 0;
            for (int i = 0; i < DEB; i++) if (hist[ch][i] == m_filt[ch]) flip = 0;
            nf = (flip != 0) ? 1 - m_filt[ch] : m_filt[ch];
            arrival = (nf == 1 && m_filt[ch] == 0) ? 1 : 0;
            if (arrival != 0) begin
                m_cnt[ch] = (m_cnt[ch] < CMAX) ? m_cnt[ch] + 1 : CMAX;
                m_rise[ch] = edge_no;
            end
            if (gr[ch] != 0) m_req[ch] = 0;
            else if (arrival != 0) m_req[ch] = 1;
            m_fault[ch] = (nf == 1 && (edge_no - m_rise[ch]) >= STK) ? 1 : 0;
            m_filt[ch] = nf;
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = lp[ch];
        end
    endtask

    function automatic int m_sreq(input int ch);
        return (m_req[ch] != 0 || (m_filt[ch] != 0 && m_fault[ch] == 0)) ? 1 : 0;
    endfunction

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".Sa"}, 32'(Sa), 32'(m_sreq(0)));
        chk({tag, ".Sb"}, 32'(Sb), 32'(m_sreq(1)));
        chk({tag, ".count_a"}, 32'(count_a), 32'(m_cnt[0]));
        chk({tag, ".count_b"}, 32'(count_b), 32'(m_cnt[1]));
        chk({tag, ".fault_a"}, 32'(fault_a), 32'(m_fault[0]));
        chk({tag, ".fault_b"}, 32'(fault_b), 32'(m_fault[1]));
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        reset = 1'b1; loop_a = 1'b0; loop_b = 1'b0; Ga = 1'b0; Gb = 1'b0;
        ticks("reset", 3);
        reset = 1'b0;
        ticks("idle", 4);

        // Held detector on A: request appears after full latency.
        loop_a = 1'b1;
        ticks("rise_a", 5);
        chk("rise_a.latency_before", 32'(Sa), 32'(0));
        tick("rise_a");
        chk("rise_a.latency_at", 32'(Sa), 32'(1));
        ticks("rise_a", 6);
        chk("rise_a.count_a", 32'(count_a), 32'(1));
        chk("rise_a.Sb", 32'(Sb), 32'(0));
        chk("rise_a.count_b", 32'(count_b), 32'(0));
        loop_a = 1'b0;
        ticks("hold_a", 8);
        chk("hold_a.latched", 32'(Sa), 32'(1));
        Ga = 1'b1;
        tick("serve_a");
        Ga = 1'b0;
        chk("serve_a.cleared", 32'(Sa), 32'(0));
        ticks("serve_a", 3);

        // Short glitches on B never qualify.
        for (int r = 0; r < 10; r++) begin
            loop_b = 1'b1;
            ticks("glitch_b", 3);
            loop_b = 1'b0;
            ticks("glitch_b", 3);
        end
        chk("glitch_b.Sb", 32'(Sb), 32'(0));
        chk("glitch_b.count_b", 32'(count_b), 32'(0));

        // Short pulse on A latched until green at cycle 40.
        loop_a = 1'b1;
        ticks("pulse_a", 8);
        loop_a = 1'b0;
        ticks("pulse_a", 31);
        chk("pulse_a.latched", 32'(Sa), 32'(1));
        Ga = 1'b1;
        tick("pulse_a_serve");
        Ga = 1'b0;
        chk("pulse_a.cleared", 32'(Sa), 32'(0));
        ticks("pulse_a", 3);

        // Arrival during green: no latch, Sa tracks the filtered level.
        Ga = 1'b1;
        loop_a = 1'b1;
        ticks("green_arr", 10);
        chk("green_arr.filt", 32'(Sa), 32'(1));
        loop_a = 1'b0;
        ticks("green_arr", 5);
        chk("green_arr.before_drop", 32'(Sa), 32'(1));
        tick("green_arr");
        chk("green_arr.dropped", 32'(Sa), 32'(0));
        Ga = 1'b0;
        ticks("green_arr", 3);

        // Stuck detector on B.
        loop_b = 1'b1;
        ticks("stuck_b", 10);
        Gb = 1'b1;
        tick("stuck_b");
        Gb = 1'b0;
        ticks("stuck_b", 19);
        chk("stuck_b.fault", 32'(fault_b), 32'(1));
        chk("stuck_b.Sb", 32'(Sb), 32'(0));
        loop_b = 1'b0;
        ticks("release_b", 6);
        chk("release_b.fault", 32'(fault_b), 32'(0));

        // Saturation of the arrival counter.
        reset = 1'b1;
        tick("sat_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            loop_a = 1'b1;
            ticks("sat_a", 6);
            chk("sat_a.count", 32'(count_a), 32'((i + 1 < CMAX) ? i + 1 : CMAX));
            loop_a = 1'b0;
            ticks("sat_a", 6);
            Ga = 1'b1;
            tick("sat_a");
            Ga = 1'b0;
        end

        // Reset mid-pulse, then re-qualify with full latency.
        loop_a = 1'b1;
        ticks("mid_reset", 7);
        reset = 1'b1;
        tick("mid_reset");
        chk("mid_reset.Sa", 32'(Sa), 32'(0));
        chk("mid_reset.count_a", 32'(count_a), 32'(0));
        reset = 1'b0;
        ticks("requal", 5);
        chk("requal.before", 32'(Sa), 32'(0));
        tick("requal");
        chk("requal.at", 32'(Sa), 32'(1));
        loop_a = 1'b0;
        ticks("requal", 8);

        // Random activity.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) loop_a = ~loop_a;
            if ($urandom_range(5) == 0) loop_b = ~loop_b;
            Ga = ($urandom_range(15) == 0);
            Gb = ($urandom_range(15) == 0);
            reset = ($urandom_range(599) == 0);
            tick("random");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Per-approach vehicle-detector front end that produces the Sa/Sb request inputs consumed by the two-road traffic light controller. It takes raw, asynchronous, bouncy loop-detector levels for roads A and B and synchronizes and debounces them. It latches a vehicle request until the controller serves that road with green (Ga/Gb feedback), counts arrivals and flags stuck detectors. Two identical channels (A, B) share clock and reset.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized input must differ from the filtered level before the filtered level changes (>=1)
STUCK_CYCLES, 1024, consecutive cycles of filtered-high before a detector is declared stuck (>=2)
CNT_W, 8, width of each saturating arrival counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
loop_a  input  1  raw road-A detector, asynchronous to clk
loop_b  input  1  raw road-B detector, asynchronous to clk
Ga  input  1  road-A green from controller (served indication)
Gb  input  1  road-B green from controller
Sa  output  1  road-A vehicle request to controller
Sb  output  1  road-B vehicle request to controller
count_a  output  CNT_W  road-A arrivals, saturating
count_b  output  CNT_W  road-B arrivals, saturating
fault_a  output  1  road-A detector stuck high
fault_b  output  1  road-B detector stuck high

Behaviour:
- One clock and one reset: clk, rising edge. reset is synchronous and active-high. Reset clears every register: sync flops, filtered level, debounce counter, request latch, stuck counter, count, fault. All outputs are 0 during and after reset. Reset mid-operation discards pending requests and counts. After reset, a detector still held high re-qualifies with full latency.
- Per channel (A shown; B identical with loop_b/Gb):
- Synchronizer: two flops, loop_a -> s1 -> s2.
- Debounce: counter dcnt. Each cycle s2 == filt -> dcnt <= 0. Each cycle s2 != filt -> dcnt increments; on the cycle dcnt == DEBOUNCE_CYCLES-1 -> filt <= s2, dcnt <= 0. A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes filt.
- Arrival event: the cycle in which filt transitions 0->1.
- On arrival, count_a increments and saturates at 2^CNT_W-1 with no wrap.
- On arrival with Ga==0, the request latch req_a is set.
- Latch clear: req_a <= 0 on any edge where Ga==1. Clear has priority over set; an arrival during green sets nothing.
- Stuck detect: scnt counts consecutive cycles with filt==1 and saturates at STUCK_CYCLES. fault_a <= 1 when scnt reaches STUCK_CYCLES. fault_a and scnt clear on the cycle filt falls.
- Output: Sa = req_a | (filt & ~fault_a), decoded from registers only with no combinational path from inputs. A stuck detector therefore cannot hold Sa high indefinitely. Once the road is served, Sa drops while fault is set.
- Latency: raw edge first sampled at edge k -> filt and Sa change at edge k+1+DEBOUNCE_CYCLES (edge k+5 for default 4). Falling Sa while req_a==0 follows the same latency.
- Channels are fully independent. Simultaneous arrivals on A and B in the same cycle are both registered.

Test Plan:
- Reset then loop_a=1 held, Ga=0 -> Sa rises exactly 5 edges after the first sampling edge; count_a=1; Sb=0, count_b=0.
- loop_b pulse 3 cycles wide (shorter than debounce), repeated 10 times -> Sb stays 0, count_b=0.
- loop_a 8-cycle pulse with Ga=0 then released; Ga pulsed 1 at cycle 40 -> Sa high from arrival until the edge after Ga is sampled 1, then 0; count_a=1.
- loop_a arrival while Ga=1 -> req_a not set; Sa follows filt only and drops 5 edges after loop_a falls.
- STUCK_CYCLES=16, loop_b held 1, Gb pulsed once -> fault_b=1 after 16 filtered-high cycles; Sb drops after Gb; releasing loop_b clears fault_b.
- CNT_W=2, 5 clean arrivals on A -> count_a sequence 1,2,3,3,3; reset asserted mid-pulse -> all outputs 0 next edge.
